// File: rtl/mult_seq_param.sv
// Sequential shift-add multiplier with a start/busy/done handshake.
// Parametrised width, full-width product, optional two's-complement mode and early exit.
module mult_seq_param #(
    parameter int WIDTH     = 16,
    parameter bit SIGNED_EN = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 signed_mode,
    input  logic [WIDTH-1:0]     m_in,
    input  logic [WIDTH-1:0]     n_in,
    output logic [2*WIDTH-1:0]   prod,
    output logic                 busy,
    output logic                 done
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        FINISH = 2'd2
    } state_t;

    state_t             state;
    logic [2*WIDTH-1:0] m_reg;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   n_reg;
    logic               neg;

    logic               sgn;
    logic               m_neg;
    logic               n_neg;
    logic [WIDTH-1:0]   m_abs;
    logic [WIDTH-1:0]   n_abs;

    // Operand magnitudes; -2^(WIDTH-1) wraps to itself, which is correct as an unsigned magnitude.
    // NOTE: every signal gets a value on every path through always_comb, so no latch is inferred.
    always_comb begin
        sgn   = SIGNED_EN & signed_mode;
        m_neg = sgn & m_in[WIDTH-1];
        n_neg = sgn & n_in[WIDTH-1];
        m_abs = m_neg ? (~m_in + 1'b1) : m_in;
        n_abs = n_neg ? (~n_in + 1'b1) : n_in;
    end

    // NOTE: sequential state uses non-blocking assignments so every register updates from pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            m_reg <= '0;
            acc   <= '0;
            n_reg <= '0;
            neg   <= 1'b0;
            prod  <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        m_reg <= {{WIDTH{1'b0}}, m_abs};
                        n_reg <= n_abs;
                        neg   <= m_neg ^ n_neg;
                        acc   <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end
                end
                RUN: begin
                    // Stop as soon as no multiplier bits remain; latency tracks bit length of |n|.
                    if (n_reg == '0) begin
                        state <= FINISH;
                    end else begin
                        if (n_reg[0]) begin
                            acc <= acc + m_reg;
                        end
                        m_reg <= m_reg << 1;
                        n_reg <= n_reg >> 1;
                    end
                end
                FINISH: begin
                    prod  <= neg ? (~acc + 1'b1) : acc;
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mult_seq_param.sv
// Scoreboard bench for mult_seq_param: directed vectors push expected product and done cycle,
// monitors pop and compare on every done pulse.
module tb_mult_seq_param;

    logic        clk;
    logic        rst;
    logic        start_a, sm_a, start_b, sm_b;
    logic [15:0] m_a, n_a, m_b, n_b;
    logic [31:0] prod_a, prod_b;
    logic        busy_a, busy_b, done_a, done_b;

    typedef struct {
        logic [31:0] prod;
        int          cyc;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];
    int   cyc;
    int   total;
    int   bad;

    mult_seq_param #(.WIDTH(16), .SIGNED_EN(1'b1)) u_dut (
        .clk(clk), .rst(rst), .start(start_a), .signed_mode(sm_a),
        .m_in(m_a), .n_in(n_a), .prod(prod_a), .busy(busy_a), .done(done_a)
    );

    mult_seq_param #(.WIDTH(16), .SIGNED_EN(1'b0)) u_dut_u (
        .clk(clk), .rst(rst), .start(start_b), .signed_mode(sm_b),
        .m_in(m_b), .n_in(n_b), .prod(prod_b), .busy(busy_b), .done(done_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitors: compare on each done pulse, away from the rising edge.
    always @(negedge clk) begin
        if (!rst && done_a) begin
            if (qa.size() == 0) begin
                check("a_unexpected_done", 64'd1, 64'd0);
            end else begin
                exp_t e;
                e = qa.pop_front();
                check("a_prod", prod_a, e.prod);
                check("a_done_cycle", cyc, e.cyc);
                check("a_busy_at_done", busy_a, 1'b0);
            end
        end
        if (!rst && done_b) begin
            if (qb.size() == 0) begin
                check("b_unexpected_done", 64'd1, 64'd0);
            end else begin
                exp_t e;
                e = qb.pop_front();
                check("b_prod", prod_b, e.prod);
                check("b_done_cycle", cyc, e.cyc);
                check("b_busy_at_done", busy_b, 1'b0);
            end
        end
    end

    // Called at #1 after an edge. lat is the total latency in cycles; hold is edges start stays high.
    task automatic issue(input bit sel, input bit sm, input logic [15:0] m, input logic [15:0] n,
                         input logic [31:0] exp_prod, input int lat, input int hold);
        exp_t e;
        e.prod = exp_prod;
        e.cyc  = cyc + 1 + lat;
        if (sel) begin
            qb.push_back(e);
            start_b = 1'b1; sm_b = sm; m_b = m; n_b = n;
        end else begin
            qa.push_back(e);
            start_a = 1'b1; sm_a = sm; m_a = m; n_a = n;
        end
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            if (i == 0) begin
                // Scramble operands after acceptance; the DUT must not re-sample them.
                if (sel) begin m_b = ~m; n_b = ~n; sm_b = ~sm; end
                else     begin m_a = ~m; n_a = ~n; sm_a = ~sm; end
            end
        end
        if (sel) start_b = 1'b0;
        else     start_a = 1'b0;
    endtask

    task automatic wait_done(input bit sel, input int budget);
        int i;
        for (i = 0; i < budget; i++) begin
            @(posedge clk);
            #1;
            if (sel ? done_b : done_a) break;
        end
        if (i >= budget) begin
            total++;
            bad++;
            $display("FAIL wait_done timeout: sel=%0d waited %0d cycles", sel, budget);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        start_a = 1'b0; sm_a = 1'b0; m_a = '0; n_a = '0;
        start_b = 1'b0; sm_b = 1'b0; m_b = '0; n_b = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_prod", prod_a, 32'h0);
        check("reset_busy", busy_a, 1'b0);
        check("reset_done", done_a, 1'b0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        issue(0, 0, 16'd3, 16'd5, 32'h0000000F, 5, 1);
        check("busy_after_accept", busy_a, 1'b1);
        wait_done(0, 30);
        issue(0, 0, 16'hFFFF, 16'hFFFF, 32'hFFFE0001, 18, 1);
        wait_done(0, 30);
        issue(0, 1, 16'hFFFF, 16'h0003, 32'hFFFFFFFD, 4, 1);
        wait_done(0, 30);
        issue(0, 1, 16'h8000, 16'h8000, 32'h40000000, 18, 1);
        wait_done(0, 30);
        issue(0, 1, 16'hFFFE, 16'hFFFD, 32'h00000006, 4, 1);
        wait_done(0, 30);
        issue(0, 1, 16'h0005, 16'hFFFC, 32'hFFFFFFEC, 5, 1);
        wait_done(0, 30);
        issue(0, 0, 16'h1234, 16'h0000, 32'h00000000, 2, 1);
        wait_done(0, 30);

        // Start held through the whole operation, dropped in the done cycle.
        issue(0, 0, 16'd7, 16'd9, 32'd63, 6, 7);
        check("held_done_cycle", done_a, 1'b1);
        issue(0, 0, 16'd2, 16'd2, 32'd4, 4, 1);
        wait_done(0, 30);

        // Width-fixed unsigned instance ignores signed_mode.
        issue(1, 1, 16'h8000, 16'h8000, 32'h40000000, 18, 1);
        wait_done(1, 30);
        issue(1, 1, 16'hFFFF, 16'h0003, 32'h0002FFFD, 4, 1);
        wait_done(1, 30);

        // Reset mid-operation: abort, no done pulse, prod cleared.
        issue(0, 0, 16'hFFFF, 16'hFFFF, 32'hFFFE0001, 18, 1);
        repeat (5) @(posedge clk);
        #2;
        check("midop_busy", busy_a, 1'b1);
        #1;
        rst = 1'b1;
        #1;
        check("abort_prod", prod_a, 32'h0);
        check("abort_busy", busy_a, 1'b0);
        check("abort_done", done_a, 1'b0);
        qa.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        issue(0, 0, 16'd10, 16'd10, 32'd100, 6, 1);
        wait_done(0, 30);

        repeat (3) @(posedge clk);
        #1;
        check("qa_drained", qa.size(), 0);
        check("qb_drained", qb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
